i2s_rx: RTL

Serial audio front end for the equalizer datapath. Receives a standard Philips I2S stream (24-bit samples in 32-bit slots; the bit clock and word select are driven by an external master) and deserialises it in the system clock domain. It presents one left/right sample pair per frame with a single-cycle strobe. `audio_l` drives `equalizer.audio_in` directly. `audio_r` is available for a second channel.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_rx_sync_edge.sv | 44 ++++
 rtl/i2s_rx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and default sizes for the I2S receive front end.
// The default widths are also used by the equalizer top so that both
// sides agree on the audio sample width.
package i2s_pkg;

   localparam int SAMPLE_W_DEF  = 24;
   localparam int SLOT_BITS_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAD   = 2'd2
   } i2s_state_e;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchroniser for an asynchronous input,
// followed by a registered rising-edge detector on the synchronised level.
// SYNC_STAGES must be at least 2.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;
   logic                   prev_d;
   logic                   rise_q;
   logic                   rise_d;

   // Shift the raw input along the chain and flag a 0->1 step of its last stage
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   // Synchroniser, previous-level and edge-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = rise_q;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S receiver. Bit clock, word select and data are
// synchronised into the clk domain; the deserialiser advances once per
// detected bclk rising edge and presents one left/right pair per frame
// with a single-cycle sample_valid strobe. Framing faults pulse frame_err.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W    = SAMPLE_W_DEF,
   parameter int SLOT_BITS   = SLOT_BITS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       i2s_bclk,
   input  logic                       i2s_lrclk,
   input  logic                       i2s_sdata,
   output logic signed [SAMPLE_W-1:0] audio_l,
   output logic signed [SAMPLE_W-1:0] audio_r,
   output logic                       sample_valid,
   output logic                       frame_err
);

   localparam int                CNT_W      = $clog2(SLOT_BITS + 1);
   localparam logic [CNT_W-1:0]  SAMPLE_CNT = CNT_W'(SAMPLE_W);
   localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SLOT_BITS - 1);

   logic bclk_level;
   logic bclk_rise;
   logic tick;
   logic ws;
   logic d;
   logic boundary;

   logic [SYNC_STAGES-1:0] ws_sync_q;
   logic [SYNC_STAGES-1:0] ws_sync_d;
   logic [SYNC_STAGES-1:0] sd_sync_q;
   logic [SYNC_STAGES-1:0] sd_sync_d;

   i2s_state_e                 state_q;
   i2s_state_e                 state_d;
   logic [CNT_W-1:0]           bit_cnt_q;
   logic [CNT_W-1:0]           bit_cnt_d;
   logic [CNT_W-1:0]           bit_cnt_inc;
   logic [SAMPLE_W-1:0]        shreg_q;
   logic [SAMPLE_W-1:0]        shreg_d;
   logic [SAMPLE_W-1:0]        shreg_shift;
   logic [SAMPLE_W-1:0]        hold_l_q;
   logic [SAMPLE_W-1:0]        hold_l_d;
   logic                       left_valid_q;
   logic                       left_valid_d;
   logic                       chan_q;
   logic                       chan_d;
   logic                       ws_prev_q;
   logic                       ws_prev_d;
   logic signed [SAMPLE_W-1:0] audio_l_q;
   logic signed [SAMPLE_W-1:0] audio_l_d;
   logic signed [SAMPLE_W-1:0] audio_r_q;
   logic signed [SAMPLE_W-1:0] audio_r_d;
   logic                       sample_valid_q;
   logic                       sample_valid_d;
   logic                       frame_err_q;
   logic                       frame_err_d;

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_bclk_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (i2s_bclk),
      .level    (bclk_level),
      .rise     (bclk_rise)
   );

   // Level-only synchronisers for word select and data, same depth as bclk
   always_comb begin
      ws_sync_d = {ws_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
      sd_sync_d = {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata};
   end

   // Word select and data synchroniser registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws_sync_q <= '0;
         sd_sync_q <= '0;
      end else begin
         ws_sync_q <= ws_sync_d;
         sd_sync_q <= sd_sync_d;
      end
   end

   // A tick also requires bclk to still read high, which rejects single-cycle glitches
   assign tick     = bclk_rise & bclk_level;
   assign ws       = ws_sync_q[SYNC_STAGES-1];
   assign d        = sd_sync_q[SYNC_STAGES-1];
   assign boundary = (ws != ws_prev_q);

   assign bit_cnt_inc = bit_cnt_q + 1'b1;
   assign shreg_shift = {shreg_q[SAMPLE_W-2:0], d};

   // Deserialiser FSM next-state: framing, shifting, capture and error detection
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      shreg_d        = shreg_q;
      hold_l_d       = hold_l_q;
      left_valid_d   = left_valid_q;
      chan_d         = chan_q;
      ws_prev_d      = ws_prev_q;
      audio_l_d      = audio_l_q;
      audio_r_d      = audio_r_q;
      sample_valid_d = 1'b0;
      frame_err_d    = 1'b0;

      if (tick) begin
         ws_prev_d = ws;
      end

      if (!en) begin
         state_d      = IDLE;
         bit_cnt_d    = '0;
         shreg_d      = '0;
         left_valid_d = 1'b0;
      end else if (tick) begin
         unique case (state_q)
            IDLE: begin
               if (boundary && !ws) begin
                  bit_cnt_d    = '0;
                  shreg_d      = '0;
                  chan_d       = 1'b0;
                  left_valid_d = 1'b0;
                  state_d      = SHIFT;
               end
            end

            SHIFT: begin
               if (boundary) begin
                  frame_err_d  = 1'b1;
                  bit_cnt_d    = '0;
                  shreg_d      = '0;
                  left_valid_d = 1'b0;
                  chan_d       = 1'b0;
                  state_d      = ws ? IDLE : SHIFT;
               end else begin
                  shreg_d   = shreg_shift;
                  bit_cnt_d = bit_cnt_inc;
                  if (bit_cnt_inc == SAMPLE_CNT) begin
                     if (!chan_q) begin
                        hold_l_d     = shreg_shift;
                        left_valid_d = 1'b1;
                     end else begin
                        if (left_valid_q) begin
                           audio_l_d      = hold_l_q;
                           audio_r_d      = shreg_shift;
                           sample_valid_d = 1'b1;
                        end
                        left_valid_d = 1'b0;
                     end
                     state_d = PAD;
                  end
               end
            end

            PAD: begin
               if (boundary) begin
                  bit_cnt_d = '0;
                  shreg_d   = '0;
                  chan_d    = ws;
                  if (!ws) begin
                     left_valid_d = 1'b0;
                  end
                  state_d = SHIFT;
               end else if (bit_cnt_q == SLOT_LAST) begin
                  frame_err_d  = 1'b1;
                  left_valid_d = 1'b0;
                  state_d      = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_inc;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Deserialiser state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         shreg_q        <= '0;
         hold_l_q       <= '0;
         left_valid_q   <= 1'b0;
         chan_q         <= 1'b0;
         ws_prev_q      <= 1'b0;
         audio_l_q      <= '0;
         audio_r_q      <= '0;
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         hold_l_q       <= hold_l_d;
         left_valid_q   <= left_valid_d;
         chan_q         <= chan_d;
         ws_prev_q      <= ws_prev_d;
         audio_l_q      <= audio_l_d;
         audio_r_q      <= audio_r_d;
         sample_valid_q <= sample_valid_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign audio_l      = audio_l_q;
   assign audio_r      = audio_r_q;
   assign sample_valid = sample_valid_q;
   assign frame_err    = frame_err_q;

endmodule
